// File: rtl/serial_sub.sv
// ---------------------------------------------------------------------------
// serial_sub
//   Bit-serial two's-complement subtractor (diff = a - b), LSB first, with a
//   single borrow flop and a start/busy/done handshake.
//
//   Build option:
//     SERIAL_SUB_SAT_EN  defined   -> saturating subtract: on a final borrow
//                                     diff loads all-zeros; borrow still 1.
//                        undefined -> diff wraps modulo 2^WIDTH.
//   Timing and handshake are identical in both builds.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start; busy=0; start latches a/b
//   ST_RUN   | one bit per clock, counter 0..WIDTH-1; last bit -> done
// ---------------------------------------------------------------------------
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Reject widths the shift datapath cannot represent.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
            $error("serial_sub: WIDTH must be in 2..32");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_bw;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_d;
    logic             w_bw_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_diff_load;

    // Current bit and full-subtractor cell; operands shift right so bit i
    // always sits at position 0 when the counter reads i.
    always_comb begin
        w_a_bit    = r_a_sh[0];
        w_b_bit    = r_b_sh[0];
        w_d        = w_a_bit ^ w_b_bit ^ r_bw;
        w_bw_next  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_bw);
        w_res_next = {w_d, r_res[WIDTH-1:1]};
        w_last     = (r_cnt == LAST_BIT);
        w_accept   = (r_state == ST_IDLE) && start;
    end

    // Value loaded into diff when the last bit completes.
`ifdef SERIAL_SUB_SAT_EN
    always_comb begin
        w_diff_load = w_bw_next ? '0 : w_res_next;
    end
`else
    always_comb begin
        w_diff_load = w_res_next;
    end
`endif

    // Control: state, busy and the one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand shifters, partial result, bit counter, borrow flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bw   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_res  <= '0;
            r_cnt  <= '0;
            r_bw   <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_a_sh <= r_a_sh >> 1;
            r_b_sh <= r_b_sh >> 1;
            r_res  <= w_res_next;
            r_cnt  <= r_cnt + CW'(1);
            r_bw   <= w_bw_next;
        end
    end

    // Result registers: only touched on the final bit, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_diff   <= w_diff_load;
            r_borrow <= w_bw_next;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
